// File: rtl/prime_search_ctrl.sv
// rtl/prime_search_ctrl.sv - candidate sequencer between the candidate FIFO, primality tester and prime FIFO
// One candidate in flight at a time; trivial composites are filtered before the tester is launched.
module prime_search_ctrl #(
  parameter logic [31:0] MIN_VAL = 32'd3,
  parameter logic [15:0] TIMEOUT = 16'd4095,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cand_empty,
  output logic             cand_rd,
  input  logic [31:0]      cand_data,
  output logic             pt_start,
  output logic [31:0]      pt_cand,
  input  logic             pt_done,
  input  logic             pt_is_prime,
  input  logic             prime_full,
  output logic             prime_wr,
  output logic [31:0]      prime_data,
  output logic [CNT_W-1:0] tested_cnt,
  output logic [CNT_W-1:0] reject_cnt,
  output logic [CNT_W-1:0] prime_cnt,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_WAIT, S_PUSH
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        cand_q, cand_d;
  logic [15:0]        timer_q, timer_d;
  logic [CNT_W-1:0]   tested_q, tested_d;
  logic [CNT_W-1:0]   reject_q, reject_d;
  logic [CNT_W-1:0]   prime_q, prime_d;
  logic               tmo_q, tmo_d;
  logic               accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // 2 is the one even prime; it survives only if the floor allows it
  assign accept = ((cand_data == 32'd2) && (MIN_VAL <= 32'd2)) ||
                  (cand_data[0] && (cand_data >= MIN_VAL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cand_q   <= 32'd0;
      timer_q  <= 16'd0;
      tested_q <= '0;
      reject_q <= '0;
      prime_q  <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      timer_q  <= timer_d;
      tested_q <= tested_d;
      reject_q <= reject_d;
      prime_q  <= prime_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    timer_d  = timer_q;
    tested_d = tested_q;
    reject_d = reject_q;
    prime_d  = prime_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !cand_empty) state_d = S_POP;
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        cand_d = cand_data;
        if (accept) begin
          state_d = S_START;
        end else begin
          reject_d = sat_inc(reject_q);
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        tested_d = sat_inc(tested_q);
        timer_d  = 16'd0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // a verdict arriving on the timeout cycle takes priority
        if (pt_done) begin
          state_d = pt_is_prime ? S_PUSH : S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
          if (timer_d == TIMEOUT) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_PUSH: begin
        if (!prime_full) begin
          prime_d = sat_inc(prime_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cand_rd     = (state_q == S_POP);
  assign pt_start    = (state_q == S_START);
  // a full prime FIFO stalls the write without losing the candidate
  assign prime_wr    = (state_q == S_PUSH) && !prime_full;
  assign pt_cand     = cand_q;
  assign prime_data  = cand_q;
  assign busy        = (state_q != S_IDLE);
  assign tested_cnt  = tested_q;
  assign reject_cnt  = reject_q;
  assign prime_cnt   = prime_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// tb/tb_prime_search_ctrl.sv - scoreboard bench for prime_search_ctrl
// FIFO and tester are modelled at the falling edge; a monitor pops expected starts and writes.
module tb_prime_search_ctrl;

  logic        clk, reset, enable, cand_empty, cand_rd;
  logic [31:0] cand_data, pt_cand, prime_data;
  logic        pt_start, pt_done, pt_is_prime, prime_full, prime_wr, busy, timeout_err;
  logic [15:0] tested_cnt, reject_cnt, prime_cnt;

  prime_search_ctrl #(.MIN_VAL(32'd3), .TIMEOUT(16'd16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cand_empty(cand_empty),
    .cand_rd(cand_rd), .cand_data(cand_data), .pt_start(pt_start), .pt_cand(pt_cand),
    .pt_done(pt_done), .pt_is_prime(pt_is_prime), .prime_full(prime_full),
    .prime_wr(prime_wr), .prime_data(prime_data), .tested_cnt(tested_cnt),
    .reject_cnt(reject_cnt), .prime_cnt(prime_cnt), .busy(busy), .timeout_err(timeout_err)
  );

  int          n_cmp, n_bad;
  logic [31:0] fifo_q[$];
  int          lat_q[$];
  bit          verd_q[$];
  logic [31:0] exp_start[$];
  logic [31:0] exp_wr[$];
  int          cyc, rd_cyc, start_cyc, done_cyc, rd_count, t_cnt, rd_snap;
  bit          chk_wr_lat, tmo_prev, t_pend, t_verd;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event with value %0d expected none", name, act);
  endtask

  task automatic push_cand(input logic [31:0] v, input bit tested, input bit prime, input int lat);
    fifo_q.push_back(v);
    cand_empty = 1'b0;
    if (tested) begin
      exp_start.push_back(v);
      lat_q.push_back(lat);
      verd_q.push_back(prime);
      if (prime) exp_wr.push_back(v);
    end
  endtask

  task automatic wait_quiet(input string name, input bit need_empty, input int budget);
    int  n;
    bit  quiet;
    n = 0;
    quiet = 1'b0;
    while (!quiet && n < budget) begin
      @(negedge clk);
      n++;
      quiet = !busy && exp_start.size() == 0 && exp_wr.size() == 0 &&
              (!need_empty || fifo_q.size() == 0);
    end
    if (!quiet) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no idle after %0d cycles expected idle", name, budget);
    end
  endtask

  task automatic check_cnts(input string name, input int t, input int r, input int p);
    check32({name, "_tested"}, tested_cnt, t);
    check32({name, "_reject"}, reject_cnt, r);
    check32({name, "_prime"},  prime_cnt,  p);
  endtask

  task automatic check_zero_outputs(input string name);
    check32({name, "_cand_rd"},    cand_rd,     0);
    check32({name, "_pt_start"},   pt_start,    0);
    check32({name, "_prime_wr"},   prime_wr,    0);
    check32({name, "_pt_cand"},    pt_cand,     0);
    check32({name, "_prime_data"}, prime_data,  0);
    check32({name, "_busy"},       busy,        0);
    check32({name, "_timeout"},    timeout_err, 0);
    check_cnts(name, 0, 0, 0);
  endtask

  // monitor first, then FIFO and tester models, all on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (cand_rd) begin
        check32("cand_rd_while_empty", cand_empty, 0);
        rd_cyc = cyc;
        rd_count++;
      end
      if (pt_start) begin
        check32("start_latency", cyc - rd_cyc, 2);
        if (exp_start.size() == 0) unexpected("pt_start", pt_cand);
        else check32("pt_cand", pt_cand, exp_start.pop_front());
        start_cyc = cyc;
      end
      if (prime_wr) begin
        if (chk_wr_lat) check32("wr_latency", cyc - done_cyc, 1);
        if (exp_wr.size() == 0) unexpected("prime_wr", prime_data);
        else check32("prime_data", prime_data, exp_wr.pop_front());
      end
      if (timeout_err && !tmo_prev) check32("timeout_cycle", cyc - start_cyc, 17);
      tmo_prev = timeout_err;

      if (cand_rd && fifo_q.size() > 0) cand_data = fifo_q.pop_front();
      cand_empty = (fifo_q.size() == 0);

      pt_done = 1'b0;
      pt_is_prime = 1'b0;
      if (t_pend) begin
        t_cnt--;
        if (t_cnt == 0) begin
          pt_done = 1'b1;
          pt_is_prime = t_verd;
          t_pend = 1'b0;
          done_cyc = cyc;
        end
      end
      if (pt_start && lat_q.size() > 0) begin
        t_cnt = lat_q.pop_front();
        t_verd = verd_q.pop_front();
        t_pend = (t_cnt > 0);
      end
    end else begin
      t_pend = 1'b0;
      pt_done = 1'b0;
      tmo_prev = 1'b0;
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; rd_count = 0; rd_cyc = 0; start_cyc = 0; done_cyc = 0;
    chk_wr_lat = 1'b1; tmo_prev = 1'b0; t_pend = 1'b0; t_verd = 1'b0; t_cnt = 0;
    reset = 1'b0; enable = 1'b0; cand_empty = 1'b1; cand_data = 32'd0;
    pt_done = 1'b0; pt_is_prime = 1'b0; prime_full = 1'b0;
    #1 reset = 1'b1;
    #2 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // single prime, tester answers after 5 cycles
    enable = 1'b1;
    push_cand(32'd7, 1, 1, 5);
    wait_quiet("prime7", 1, 100);
    check_cnts("prime7", 1, 0, 1);

    // even and below-floor values are filtered; 9 is composite
    push_cand(32'd10, 0, 0, 0);
    push_cand(32'd1,  0, 0, 0);
    push_cand(32'd9,  1, 0, 4);
    wait_quiet("filter", 1, 200);
    check_cnts("filter", 2, 2, 1);

    // prime FIFO full holds the FSM in PUSH
    prime_full = 1'b1;
    push_cand(32'd13, 1, 1, 3);
    repeat (25) @(negedge clk);
    check32("full_busy", busy, 1);
    check32("full_prime_wr", prime_wr, 0);
    check32("full_prime_cnt", prime_cnt, 1);
    chk_wr_lat = 1'b0;
    prime_full = 1'b0;
    wait_quiet("full", 1, 100);
    chk_wr_lat = 1'b1;
    check_cnts("full", 3, 2, 2);

    // hung tester: timeout, then the next candidate is still fetched
    push_cand(32'd21, 1, 0, -1);
    push_cand(32'd5,  1, 1, 4);
    wait_quiet("timeout", 1, 300);
    check32("timeout_sticky", timeout_err, 1);
    check_cnts("timeout", 5, 2, 3);

    // enable dropped right after POP: 11 still completes, 15 stays queued
    push_cand(32'd11, 1, 1, 3);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!cand_rd && n < 20);
      if (!cand_rd) unexpected("no_pop_11", 0);
    end
    enable = 1'b0;
    fifo_q.push_back(32'd15);
    cand_empty = 1'b0;
    wait_quiet("enable_off", 0, 100);
    rd_snap = rd_count;
    repeat (10) @(negedge clk);
    check32("enable_off_no_rd", rd_count, rd_snap);
    check32("enable_off_fifo", fifo_q.size(), 1);
    check_cnts("enable_off", 6, 2, 4);

    // async reset in the middle of WAIT
    exp_start.push_back(32'd15);
    lat_q.push_back(-1);
    verd_q.push_back(1'b0);
    enable = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_start.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (exp_start.size() != 0) unexpected("no_start_15", 0);
    end
    repeat (5) @(negedge clk);
    check32("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check_zero_outputs("async_reset");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
